// File: rtl/mac_pkg.sv
// Shared MAC definitions: framing constants and the header-insert FSM encoding.
package mac_pkg;

  localparam int unsigned MAC_HDR_LEN     = 14;
  localparam int unsigned MAC_MIN_FRAME   = 60;
  localparam int unsigned MAC_MAX_PAYLOAD = 1500;
  localparam logic [63:0] PREAMBLE_REG    = 64'h5555_5555_5555_55D5;

  typedef enum logic [2:0] {
    HDR_IDLE,
    HDR_HEADER,
    HDR_PAYLOAD,
    HDR_PAD,
    HDR_DROP
  } mac_tx_hdr_state_t;

endpackage

// File: rtl/mac_tx_header_insert.sv
// Prepends the Ethernet header to a payload byte stream, pads short frames to the
// minimum length and truncates oversize payloads, with a single output register stage.
module mac_tx_header_insert
  import mac_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_00_01_02,
  parameter int unsigned MIN_FRAME   = MAC_MIN_FRAME,
  parameter int unsigned MAX_PAYLOAD = MAC_MAX_PAYLOAD
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  mac_rnet_data_in,
  input  logic        mac_rnet_valid_in,
  output logic        mac_rnet_ready_out,
  input  logic        mac_rnet_last_in,
  input  logic [47:0] mac_dst_in,
  input  logic [15:0] mac_type_in,
  output logic [7:0]  mac_tcrc_data_out,
  output logic        mac_tcrc_valid_out,
  input  logic        mac_tcrc_ready_in,
  output logic        mac_tcrc_last_out,
  output logic        mac_trunc_err_out
);

  localparam logic [10:0] HDR_LAST_IDX = 11'(MAC_HDR_LEN - 1);
  localparam logic [10:0] MIN_FRAME_W  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_PAY_W    = 11'(MAX_PAYLOAD);

  mac_tx_hdr_state_t state_q, state_d;

  logic [47:0] dst_q;
  logic [15:0] type_q;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        trunc_q, trunc_d;
  logic [7:0]  hdr_byte;
  logic        adv;
  logic        accept;

  // Output register can take a new byte when empty or being drained this cycle.
  assign adv                = !valid_q || mac_tcrc_ready_in;
  assign mac_rnet_ready_out = ((state_q == HDR_PAYLOAD) && adv) || (state_q == HDR_DROP);
  assign accept             = mac_rnet_valid_in && mac_rnet_ready_out;

  assign mac_tcrc_data_out  = data_q;
  assign mac_tcrc_valid_out = valid_q;
  assign mac_tcrc_last_out  = last_q;
  assign mac_trunc_err_out  = trunc_q;

  always_comb begin
    hdr_byte = '0;
    case (byte_cnt_q[3:0])
      4'd0:    hdr_byte = dst_q[47:40];
      4'd1:    hdr_byte = dst_q[39:32];
      4'd2:    hdr_byte = dst_q[31:24];
      4'd3:    hdr_byte = dst_q[23:16];
      4'd4:    hdr_byte = dst_q[15:8];
      4'd5:    hdr_byte = dst_q[7:0];
      4'd6:    hdr_byte = LOCAL_MAC[47:40];
      4'd7:    hdr_byte = LOCAL_MAC[39:32];
      4'd8:    hdr_byte = LOCAL_MAC[31:24];
      4'd9:    hdr_byte = LOCAL_MAC[23:16];
      4'd10:   hdr_byte = LOCAL_MAC[15:8];
      4'd11:   hdr_byte = LOCAL_MAC[7:0];
      4'd12:   hdr_byte = type_q[15:8];
      4'd13:   hdr_byte = type_q[7:0];
      default: hdr_byte = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    trunc_d    = 1'b0;

    if (adv) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      HDR_IDLE: begin
        byte_cnt_d = '0;
        pay_cnt_d  = '0;
        if (mac_rnet_valid_in) state_d = HDR_HEADER;
      end
      HDR_HEADER: begin
        if (adv) begin
          data_d     = hdr_byte;
          valid_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q == HDR_LAST_IDX) state_d = HDR_PAYLOAD;
        end
      end
      HDR_PAYLOAD: begin
        if (accept) begin
          data_d     = mac_rnet_data_in;
          valid_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + 11'd1;
          pay_cnt_d  = pay_cnt_q + 11'd1;
          // A last flag wins over the size limit on the same byte.
          if (mac_rnet_last_in) begin
            if ((byte_cnt_q + 11'd1) >= MIN_FRAME_W) begin
              last_d  = 1'b1;
              state_d = HDR_IDLE;
            end else begin
              state_d = HDR_PAD;
            end
          end else if ((pay_cnt_q + 11'd1) == MAX_PAY_W) begin
            last_d  = 1'b1;
            trunc_d = 1'b1;
            state_d = HDR_DROP;
          end
        end
      end
      HDR_PAD: begin
        if (adv) begin
          data_d     = '0;
          valid_d    = 1'b1;
          byte_cnt_d = byte_cnt_q + 11'd1;
          if ((byte_cnt_q + 11'd1) >= MIN_FRAME_W) begin
            last_d  = 1'b1;
            state_d = HDR_IDLE;
          end
        end
      end
      HDR_DROP: begin
        if (mac_rnet_valid_in && mac_rnet_last_in) state_d = HDR_IDLE;
      end
      default: state_d = HDR_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q    <= HDR_IDLE;
      dst_q      <= '0;
      type_q     <= '0;
      byte_cnt_q <= '0;
      pay_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      trunc_q    <= trunc_d;
      if ((state_q == HDR_IDLE) && mac_rnet_valid_in) begin
        dst_q  <= mac_dst_in;
        type_q <= mac_type_in;
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_header_insert.sv
// Directed/randomized bench for mac_tx_header_insert with a frame-level reference model.
module tb_mac_tx_header_insert;

  localparam logic [47:0] LMAC = 48'h00_0A_35_00_01_02;

  typedef logic [7:0] byte_q_t[$];

  logic        logic_clk = 1'b0;
  logic        logic_rst = 1'b1;
  logic [7:0]  mac_rnet_data_in = '0;
  logic        mac_rnet_valid_in = 1'b0;
  logic        mac_rnet_ready_out;
  logic        mac_rnet_last_in = 1'b0;
  logic [47:0] mac_dst_in = '0;
  logic [15:0] mac_type_in = '0;
  logic [7:0]  mac_tcrc_data_out;
  logic        mac_tcrc_valid_out;
  logic        mac_tcrc_ready_in = 1'b1;
  logic        mac_tcrc_last_out;
  logic        mac_trunc_err_out;

  mac_tx_header_insert #(
    .LOCAL_MAC  (LMAC),
    .MIN_FRAME  (60),
    .MAX_PAYLOAD(1500)
  ) dut (
    .logic_clk         (logic_clk),
    .logic_rst         (logic_rst),
    .mac_rnet_data_in  (mac_rnet_data_in),
    .mac_rnet_valid_in (mac_rnet_valid_in),
    .mac_rnet_ready_out(mac_rnet_ready_out),
    .mac_rnet_last_in  (mac_rnet_last_in),
    .mac_dst_in        (mac_dst_in),
    .mac_type_in       (mac_type_in),
    .mac_tcrc_data_out (mac_tcrc_data_out),
    .mac_tcrc_valid_out(mac_tcrc_valid_out),
    .mac_tcrc_ready_in (mac_tcrc_ready_in),
    .mac_tcrc_last_out (mac_tcrc_last_out),
    .mac_trunc_err_out (mac_trunc_err_out)
  );

  always #5 logic_clk = ~logic_clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  exp_q[$];
  int          out_cnt = 0;
  int          trunc_seen = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          ignore = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: header fields, payload capped at 1500, zero pad to 60, last on final byte.
  task automatic model_frame(input logic [47:0] dst, input logic [15:0] typ, input byte_q_t pl);
    logic [111:0] hdr;
    logic [8:0]   tmp;
    int           n;
    int           total;
    hdr = {dst, LMAC, typ};
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, hdr[111 - 8*i -: 8]});
    n = (pl.size() > 1500) ? 1500 : pl.size();
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pl[i]});
    total = 14 + n;
    while (total < 60) begin
      exp_q.push_back(9'h000);
      total++;
    end
    tmp = exp_q.pop_back();
    tmp[8] = 1'b1;
    exp_q.push_back(tmp);
  endtask

  // Output-side monitor: drives ready, scores each transfer, checks hold-while-stalled.
  initial begin
    bit         held_valid;
    logic [7:0] held_data;
    logic       held_last;
    logic [8:0] e;
    held_valid = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    forever begin
      @(negedge logic_clk);
      cyc++;
      mac_tcrc_ready_in = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (logic_rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          check("stall_valid", mac_tcrc_valid_out, 1'b1);
          check("stall_data", mac_tcrc_data_out, held_data);
          check("stall_last", mac_tcrc_last_out, held_last);
        end
        held_valid = mac_tcrc_valid_out && !mac_tcrc_ready_in;
        held_data  = mac_tcrc_data_out;
        held_last  = mac_tcrc_last_out;
        if (mac_tcrc_valid_out && mac_tcrc_ready_in) begin
          if (out_cnt == 0) first_cyc = cyc;
          out_cnt++;
          if (!ignore) begin
            if (exp_q.size() == 0) begin
              check("extra_byte", {mac_tcrc_last_out, mac_tcrc_data_out}, 9'h1FF);
            end else begin
              e = exp_q.pop_front();
              check("frame_byte", {mac_tcrc_last_out, mac_tcrc_data_out}, e);
              if (e[8]) last_cyc = cyc;
            end
          end
        end
        if (mac_trunc_err_out) trunc_seen++;
      end
    end
  end

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ, input byte_q_t pl);
    bit ok;
    model_frame(dst, typ, pl);
    for (int i = 0; i < pl.size(); i++) begin
      mac_rnet_valid_in = 1'b1;
      mac_rnet_data_in  = pl[i];
      mac_rnet_last_in  = (i == pl.size() - 1);
      if (i == 0) begin
        mac_dst_in  = dst;
        mac_type_in = typ;
      end
      ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
        @(negedge logic_clk);
        #1;
        ok = mac_rnet_ready_out;
        @(posedge logic_clk);
        #1;
      end
      if (!ok) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
      if (i == 0) begin
        mac_dst_in  = {$urandom, $urandom_range(0, 65535)};
        mac_type_in = 16'($urandom);
      end
    end
    mac_rnet_valid_in = 1'b0;
    mac_rnet_last_in  = 1'b0;
  endtask

  task automatic wait_drain(input int exp_len, input int exp_trunc, input bit chk_tp);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mac_tcrc_valid_out) && k < 5000) begin
      @(posedge logic_clk);
      #1;
      k++;
    end
    check("drain_left", exp_q.size(), 0);
    check("out_len", out_cnt, exp_len);
    check("trunc_cnt", trunc_seen, exp_trunc);
    if (chk_tp) check("no_bubble", last_cyc - first_cyc, exp_len - 1);
    exp_q.delete();
    out_cnt    = 0;
    trunc_seen = 0;
    @(posedge logic_clk);
    #1;
  endtask

  task automatic make_payload(input int n, input bit ramp, output byte_q_t pl);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(ramp ? 8'(i + 1) : 8'($urandom));
  endtask

  initial begin
    byte_q_t pl;
    bit      ok;
    repeat (3) @(posedge logic_clk);
    #1;
    check("rst_valid", mac_tcrc_valid_out, 1'b0);
    check("rst_last", mac_tcrc_last_out, 1'b0);
    check("rst_data", mac_tcrc_data_out, 8'h00);
    check("rst_trunc", mac_trunc_err_out, 1'b0);
    check("rst_ready", mac_rnet_ready_out, 1'b0);
    logic_rst = 1'b0;
    @(posedge logic_clk);
    #1;

    // 46-byte ramp payload: exactly the minimum frame, plus header-start latency.
    make_payload(46, 1'b1, pl);
    mac_rnet_valid_in = 1'b1;
    mac_rnet_data_in  = pl[0];
    mac_dst_in        = 48'hFFFF_FFFF_FFFF;
    mac_type_in       = 16'h0800;
    @(posedge logic_clk);
    #1;
    check("lat_cycle1", mac_tcrc_valid_out, 1'b0);
    @(posedge logic_clk);
    #1;
    check("lat_cycle2", mac_tcrc_valid_out, 1'b1);
    check("lat_first", mac_tcrc_data_out, 8'hFF);
    send_frame(48'hFFFF_FFFF_FFFF, 16'h0800, pl);
    wait_drain(60, 0, 1'b1);

    // Short payload padded to 60.
    make_payload(10, 1'b0, pl);
    send_frame({$urandom, 16'($urandom)}, 16'h86DD, pl);
    wait_drain(60, 0, 1'b1);

    // Oversize payload truncated at 1500, then a clean follow-up frame.
    make_payload(1501, 1'b0, pl);
    send_frame(48'h0203_0405_0607, 16'h0806, pl);
    wait_drain(1514, 1, 1'b1);
    make_payload(20, 1'b0, pl);
    send_frame(48'h1122_3344_5566, 16'h0800, pl);
    wait_drain(60, 0, 1'b1);

    // Random downstream backpressure.
    rand_ready = 1'b1;
    make_payload(100, 1'b0, pl);
    send_frame({$urandom, 16'($urandom)}, 16'($urandom), pl);
    wait_drain(114, 0, 1'b0);
    rand_ready = 1'b0;
    @(posedge logic_clk);
    #1;

    // Back-to-back 64-byte frames with distinct header fields.
    make_payload(64, 1'b0, pl);
    send_frame(48'hA1A2_A3A4_A5A6, 16'h1234, pl);
    make_payload(64, 1'b0, pl);
    send_frame(48'hB1B2_B3B4_B5B6, 16'h5678, pl);
    wait_drain(156, 0, 1'b0);

    // Reset mid-frame around output byte 20.
    ignore            = 1'b1;
    mac_rnet_valid_in = 1'b1;
    mac_rnet_data_in  = 8'h5A;
    mac_rnet_last_in  = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge logic_clk);
      #2;
      ok = (out_cnt >= 20);
    end
    check("rst_reach", ok, 1'b1);
    logic_rst         = 1'b1;
    mac_rnet_valid_in = 1'b0;
    @(posedge logic_clk);
    #1;
    check("mid_rst_valid", mac_tcrc_valid_out, 1'b0);
    check("mid_rst_last", mac_tcrc_last_out, 1'b0);
    check("mid_rst_data", mac_tcrc_data_out, 8'h00);
    check("mid_rst_trunc", mac_trunc_err_out, 1'b0);
    check("mid_rst_ready", mac_rnet_ready_out, 1'b0);
    @(posedge logic_clk);
    #1;
    logic_rst  = 1'b0;
    ignore     = 1'b0;
    out_cnt    = 0;
    trunc_seen = 0;
    exp_q.delete();
    @(posedge logic_clk);
    #1;
    make_payload(46, 1'b0, pl);
    send_frame(48'h0A0B_0C0D_0E0F, 16'h0800, pl);
    wait_drain(60, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
